// File: rtl/load_store_unit_pkg.sv
// Shared constants, state encoding and request-legality helpers for load_store_unit.
package lsu_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int XLEN_DEF   = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STORE   = 3'd1,
        LD_ADDR = 3'd2,
        LD_DATA = 3'd3,
        RESP    = 3'd4
    } state_t;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Half accesses (x01) need addr[0]=0, word accesses (010) need addr[1:0]=0.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signal bundle of load_store_unit.
// Handshake: a request transfers on a rising edge with req_valid && req_ready; resp_valid is a one-cycle pulse with no backpressure.
interface load_store_unit_if #(
    parameter int ADDR_W = lsu_pkg::ADDR_W_DEF,
    parameter int XLEN   = lsu_pkg::XLEN_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    logic              mem_write;
    logic [3:0]        mem_byte_en;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [XLEN-1:0]   mem_write_data;
    logic [XLEN-1:0]   mem_read_data;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_write, mem_byte_en, mem_write_addr, mem_read_addr, mem_write_data
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_write, mem_byte_en, mem_write_addr, mem_read_addr, mem_write_data
    );
endinterface

// File: rtl/load_store_unit_align.sv
// load_align: combinational selection and sign/zero extension of a memory word for RV32I loads.
module load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] word_i,
    output logic [XLEN-1:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? word_i[16 +: 16] : word_i[0 +: 16];
        data_o   = '0;
        case (funct3_i)
            F3_B:    data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_H:    data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_sel};
            default: data_o = '0;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding initiator for the synchronous data memory.
// Build option LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int XLEN   = XLEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus,
    output state_t           state_o
);
    state_t            state_q;
    logic [2:0]        funct3_q;
    logic              mem_write_q;
    logic [3:0]        byte_en_q;
    logic [ADDR_W-1:0] write_addr_q;
    logic [ADDR_W-1:0] read_addr_q;
    logic [XLEN-1:0]   write_data_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [XLEN-1:0]   rdata_q;

    logic              req_err;
    logic [3:0]        st_be;
    logic [XLEN-1:0]   st_wd;
    logic [XLEN-1:0]   ld_fmt;
    logic              unused_addr_hi;

    // Address bits above ADDR_W wrap into the memory space.
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

    always_comb begin
        req_err = !f3_legal(bus.req_is_store, bus.req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
            req_err = 1'b1;
        end
`endif
    end

    always_comb begin
        st_be = 4'b1111;
        st_wd = bus.req_wdata;
        case (bus.req_funct3)
            F3_B: begin
                st_be = 4'b0001 << bus.req_addr[1:0];
                st_wd = {4{bus.req_wdata[7:0]}};
            end
            F3_H: begin
                st_be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                st_wd = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // read_addr_q still holds the load address during LD_DATA.
    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (read_addr_q[1:0]),
        .word_i    (bus.mem_read_data),
        .data_o    (ld_fmt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            funct3_q     <= '0;
            mem_write_q  <= 1'b0;
            byte_en_q    <= '0;
            write_addr_q <= '0;
            read_addr_q  <= '0;
            write_data_q <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        funct3_q   <= bus.req_funct3;
                        rdata_q    <= '0;
                        resp_err_q <= 1'b0;
                        if (req_err) begin
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else if (bus.req_is_store) begin
                            mem_write_q  <= 1'b1;
                            byte_en_q    <= st_be;
                            write_addr_q <= bus.req_addr[ADDR_W-1:0];
                            write_data_q <= st_wd;
                            state_q      <= STORE;
                        end else begin
                            read_addr_q <= bus.req_addr[ADDR_W-1:0];
                            state_q     <= LD_ADDR;
                        end
                    end
                end
                STORE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                LD_ADDR: begin
                    state_q <= LD_DATA;
                end
                LD_DATA: begin
                    rdata_q      <= ld_fmt;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready      = (state_q == IDLE);
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_byte_en    = byte_en_q;
    assign bus.mem_write_addr = write_addr_q;
    assign bus.mem_read_addr  = read_addr_q;
    assign bus.mem_write_data = write_data_q;
    assign state_o            = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table plus busy/reset sequences, with a behavioural synchronous memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int wr_cnt    = 0;
    logic [32:0] exp_q[$];

    logic [31:0] mem [0:65535];
    logic [31:0] mem_rd;
    assign bus.mem_read_data = mem_rd;

    always @(posedge clk) begin
        logic [31:0] w;
        if (bus.mem_write) begin
            w = mem[bus.mem_write_addr[17:2]];
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_byte_en[b]) w[8*b +: 8] = bus.mem_write_data[8*b +: 8];
            end
            mem[bus.mem_write_addr[17:2]] <= w;
        end
        mem_rd <= mem[bus.mem_read_addr[17:2]];
    end

    always @(posedge clk) begin
        if (rst && bus.mem_write) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", bus.resp_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_err_rdata", {bus.resp_err, bus.resp_rdata}, e);
            end
        end
    end

    function automatic logic [35:0] exp_store(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] wd);
        case (f3)
            3'b000:  return {4'b0001 << o, {4{wd[7:0]}}};
            3'b001:  return {(o[1] ? 4'b1100 : 4'b0011), {2{wd[15:0]}}};
            default: return {4'b1111, wd};
        endcase
    endfunction

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic err, input logic [31:0] rd);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = a; v.wd = wd; v.err = err; v.rd = rd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
    endtask

    task automatic send(input vec_t v);
        int          n;
        int          wr0;
        int          lat;
        logic [17:0] ra0;
        logic [35:0] se;
        lat = v.err ? 1 : (v.st ? 2 : 3);
        @(negedge clk);
        chk("req_ready_idle", bus.req_ready, 1);
        wr0 = wr_cnt;
        ra0 = bus.mem_read_addr;
        drive(v.st, v.f3, v.addr, v.wd);
        exp_q.push_back({v.err, v.rd});
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        chk("req_ready_busy", bus.req_ready, 0);
        if (!v.err && v.st) begin
            se = exp_store(v.f3, v.addr[1:0], v.wd);
            chk("st_mem_write", bus.mem_write, 1);
            chk("st_byte_en", bus.mem_byte_en, se[35:32]);
            chk("st_write_data", bus.mem_write_data, se[31:0]);
            chk("st_write_addr", bus.mem_write_addr, v.addr[17:0]);
        end
        if (!v.err && !v.st) chk("ld_read_addr", bus.mem_read_addr, v.addr[17:0]);
        while (!bus.resp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, lat);
        @(negedge clk);
        chk("mem_write_count", wr_cnt - wr0, (v.st && !v.err) ? 1 : 0);
        if (v.err) chk("no_read_on_err", bus.mem_read_addr, ra0);
        else if (!v.st) chk("read_addr_hold", bus.mem_read_addr, v.addr[17:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wr0;
        vec_t v;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[16'h0040] = 32'h8899AABB;
        mem[16'h0041] = 32'h7F008001;
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

        // Loads of preset words
        add(0, 3'b000, 32'h102, 0, 0, 32'hFFFFFF99);
        add(0, 3'b100, 32'h102, 0, 0, 32'h00000099);
        add(0, 3'b000, 32'h100, 0, 0, 32'hFFFFFFBB);
        add(0, 3'b001, 32'h102, 0, 0, 32'hFFFF8899);
        add(0, 3'b101, 32'h100, 0, 0, 32'h0000AABB);
        add(0, 3'b010, 32'h100, 0, 0, 32'h8899AABB);
        add(0, 3'b100, 32'h103, 0, 0, 32'h00000088);
        add(0, 3'b001, 32'h106, 0, 0, 32'h00007F00);
        add(0, 3'b001, 32'h104, 0, 0, 32'hFFFF8001);
        add(0, 3'b000, 32'h104, 0, 0, 32'h00000001);
        add(0, 3'b010, 32'h0004_0100, 0, 0, 32'h8899AABB);
        // Illegal funct3
        add(0, 3'b011, 32'h100, 0, 1, 32'h0);
        add(0, 3'b110, 32'h100, 0, 1, 32'h0);
        add(0, 3'b111, 32'h100, 0, 1, 32'h0);
        add(1, 3'b011, 32'h500, 32'h11111111, 1, 32'h0);
        add(1, 3'b100, 32'h500, 32'h22222222, 1, 32'h0);
        add(0, 3'b010, 32'h500, 0, 0, 32'h0);
        // Stores then read-back
        add(1, 3'b001, 32'h202, 32'h00001234, 0, 32'h0);
        add(0, 3'b010, 32'h200, 0, 0, 32'h12340000);
        add(1, 3'b000, 32'h301, 32'h000000A5, 0, 32'h0);
        add(0, 3'b010, 32'h300, 0, 0, 32'h0000A500);
        add(1, 3'b001, 32'h306, 32'hCAFEBEEF, 0, 32'h0);
        add(0, 3'b010, 32'h304, 0, 0, 32'hBEEF0000);
        add(1, 3'b010, 32'h308, 32'h01234567, 0, 32'h0);
        add(0, 3'b100, 32'h30B, 0, 0, 32'h00000001);
        add(0, 3'b001, 32'h30A, 0, 0, 32'h00000123);
        // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        add(0, 3'b010, 32'h102, 0, 1, 32'h0);
        add(0, 3'b001, 32'h101, 0, 1, 32'h0);
        add(1, 3'b001, 32'h305, 32'h00007777, 1, 32'h0);
        add(0, 3'b010, 32'h304, 0, 0, 32'hBEEF0000);
`else
        add(0, 3'b010, 32'h102, 0, 0, 32'h8899AABB);
        add(0, 3'b001, 32'h101, 0, 0, 32'hFFFFAABB);
        add(1, 3'b001, 32'h305, 32'h00007777, 0, 32'h0);
        add(0, 3'b010, 32'h304, 0, 0, 32'hBEEF7777);
`endif

        repeat (3) @(negedge clk);
        chk("rst_state", dbg_state, IDLE);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_byte_en", bus.mem_byte_en, 0);
        chk("rst_write_addr", bus.mem_write_addr, 0);
        chk("rst_read_addr", bus.mem_read_addr, 0);
        chk("rst_write_data", bus.mem_write_data, 0);
        rst = 1'b1;

        foreach (vecs[i]) send(vecs[i]);

        // SW then LW at the top of memory with req_valid held high while busy
        @(negedge clk);
        chk("b2b_ready_idle", bus.req_ready, 1);
        wr0 = wr_cnt;
        drive(1, 3'b010, 32'h3FFFC, 32'hDEADBEEF);
        exp_q.push_back({1'b0, 32'h0});
        @(negedge clk);
        drive(0, 3'b010, 32'h3FFFC, 32'h0);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        chk("b2b_ready_store", bus.req_ready, 0);
        @(negedge clk);
        chk("b2b_ready_resp1", bus.req_ready, 0);
        @(negedge clk);
        chk("b2b_ready_idle2", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("b2b_ready_ldaddr", bus.req_ready, 0);
        chk("b2b_read_addr", bus.mem_read_addr, 18'h3FFFC);
        @(negedge clk);
        chk("b2b_ready_lddata", bus.req_ready, 0);
        @(negedge clk);
        chk("b2b_ready_resp2", bus.req_ready, 0);
        chk("b2b_resp_valid", bus.resp_valid, 1);
        @(negedge clk);
        chk("b2b_ready_done", bus.req_ready, 1);
        chk("b2b_write_count", wr_cnt - wr0, 1);

        // Reset asserted during STORE abandons the access
        @(negedge clk);
        wr0 = wr_cnt;
        drive(1, 3'b000, 32'h400, 32'h0000005A);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rstmid_store_active", bus.mem_write, 1);
        #1 rst = 1'b0;
        #1;
        chk("rstmid_mem_write_drop", bus.mem_write, 0);
        chk("rstmid_req_ready", bus.req_ready, 1);
        chk("rstmid_state", dbg_state, IDLE);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("rstmid_no_write", wr_cnt - wr0, 0);
        v.st = 0; v.f3 = 3'b010; v.addr = 32'h400; v.wd = 0; v.err = 0; v.rd = 32'h0;
        send(v);
        v.addr = 32'h100; v.rd = 32'h8899AABB;
        send(v);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
